// File: rtl/gray_counter.sv
// Up/down Gray-code counter with load, synchronous clear and limit-event pulse.
// Define GRAY_CNT_SAT_EN to saturate at the limits instead of wrapping.
module gray_counter #(
  parameter int VEC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [VEC_W-1:0] load_bin_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [VEC_W-1:0] bin_o,
  output logic [VEC_W-1:0] gray_o,
  output logic [VEC_W-1:0] chg_o,
  output logic             wrap_o
);

  localparam logic [VEC_W-1:0] ZERO = {VEC_W{1'b0}};
  localparam logic [VEC_W-1:0] ONE  = {{(VEC_W-1){1'b0}}, 1'b1};
  localparam logic [VEC_W-1:0] MAX  = {VEC_W{1'b1}};

  function automatic logic [VEC_W-1:0] bin2gray(input logic [VEC_W-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  logic [VEC_W-1:0] cnt_r;
  logic [VEC_W-1:0] gray_r;
  logic [VEC_W-1:0] chg_r;
  logic             wrap_r;

  logic [VEC_W-1:0] cnt_next_s;
  logic [VEC_W-1:0] gray_next_s;
  logic [VEC_W-1:0] chg_next_s;
  logic             wrap_next_s;
  logic             at_max_s;
  logic             at_min_s;

  assign at_max_s = (cnt_r == MAX);
  assign at_min_s = (cnt_r == ZERO);

  // Next-count selection in priority order: clear, load, step, hold.
  always_comb begin
    cnt_next_s  = cnt_r;
    wrap_next_s = 1'b0;
    if (clr_i) begin
      cnt_next_s = ZERO;
    end else if (load_i) begin
      cnt_next_s = load_bin_i;
    end else if (en_i) begin
      if (up_i) begin
        if (at_max_s) begin
          wrap_next_s = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          cnt_next_s  = cnt_r;
`else
          cnt_next_s  = ZERO;
`endif
        end else begin
          cnt_next_s = cnt_r + ONE;
        end
      end else begin
        if (at_min_s) begin
          wrap_next_s = 1'b1;
`ifdef GRAY_CNT_SAT_EN
          cnt_next_s  = cnt_r;
`else
          cnt_next_s  = MAX;
`endif
        end else begin
          cnt_next_s = cnt_r - ONE;
        end
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Gray view is taken from the next count so it stays aligned with bin_o.
  always_comb begin
    gray_next_s = bin2gray(cnt_next_s);
    chg_next_s  = gray_next_s ^ gray_r;
  end

  // Output registers; all views update on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= ZERO;
      gray_r <= ZERO;
      chg_r  <= ZERO;
      wrap_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      gray_r <= gray_next_s;
      chg_r  <= chg_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign bin_o  = cnt_r;
  assign gray_o = gray_r;
  assign chg_o  = chg_r;
  assign wrap_o = wrap_r;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (VEC_W = 4) against an arithmetic model.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr_i = 1'b0;
  logic       load_i = 1'b0;
  logic [3:0] load_bin_i = 4'd0;
  logic       en_i = 1'b0;
  logic       up_i = 1'b0;
  logic [3:0] bin_o, gray_o, chg_o;
  logic       wrap_o;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int         m_cnt = 0;
  logic [3:0] e_bin = 4'd0, e_gray = 4'd0, e_chg = 4'd0;
  logic       e_wrap = 1'b0;

  gray_counter #(.VEC_W(4)) dut (
    .clk(clk), .reset(reset), .clr_i(clr_i), .load_i(load_i),
    .load_bin_i(load_bin_i), .en_i(en_i), .up_i(up_i),
    .bin_o(bin_o), .gray_o(gray_o), .chg_o(chg_o), .wrap_o(wrap_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; e_bin = 4'd0; e_gray = 4'd0; e_chg = 4'd0; e_wrap = 1'b0;
  endtask

  task automatic model_apply(input logic c, input logic l, input logic [3:0] v,
                             input logic e, input logic u);
    int n;
    logic w;
    logic [3:0] prev_gray;
    prev_gray = e_gray;
    w = 1'b0;
    n = m_cnt;
    if (c) n = 0;
    else if (l) n = int'(v);
    else if (e) begin
      if (u && m_cnt == 15) begin
        w = 1'b1;
`ifdef GRAY_CNT_SAT_EN
        n = 15;
`else
        n = 0;
`endif
      end else if (!u && m_cnt == 0) begin
        w = 1'b1;
`ifdef GRAY_CNT_SAT_EN
        n = 0;
`else
        n = 15;
`endif
      end else n = u ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
    end
    m_cnt  = n;
    e_bin  = 4'(n);
    e_gray = 4'(n ^ (n / 2));
    e_chg  = e_gray ^ prev_gray;
    e_wrap = w;
  endtask

  // drive one set of controls for one clock, then advance the model
  task automatic cycle(input logic c, input logic l, input logic [3:0] v,
                       input logic e, input logic u);
    clr_i = c; load_i = l; load_bin_i = v; en_i = e; up_i = u;
    @(posedge clk);
    #1;
    model_apply(c, l, v, e, u);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if ({bin_o, gray_o, chg_o, wrap_o} !== 13'd0) begin
      n_mis++;
      $display("FAIL reset_state: got %b want %b", {bin_o, gray_o, chg_o, wrap_o}, 13'd0);
    end
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      n_cmp++;
      if ({bin_o, gray_o, chg_o, wrap_o} !== {e_bin, e_gray, e_chg, e_wrap}) begin
        n_mis++;
        $display("FAIL count_up[%0d]: got %b want %b", i,
                 {bin_o, gray_o, chg_o, wrap_o}, {e_bin, e_gray, e_chg, e_wrap});
      end
      n_cmp++;
      if (!$onehot(chg_o) || wrap_o !== 1'b0) begin
        n_mis++;
        $display("FAIL count_up_onehot[%0d]: got chg=%b wrap=%b want one-hot/0", i, chg_o, wrap_o);
      end
    end
    n_cmp++;
    if (bin_o !== 4'd9 || gray_o !== 4'b1101) begin
      n_mis++;
      $display("FAIL count_up_nine: got bin=%0d gray=%b want 9/1101", bin_o, gray_o);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({bin_o, gray_o, chg_o, wrap_o} !== 13'd0) begin
      n_mis++;
      $display("FAIL reset_midcount: got %b want %b", {bin_o, gray_o, chg_o, wrap_o}, 13'd0);
    end
    #2;
    reset = 1'b0;
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    n_cmp++;
    if (bin_o !== 4'd1 || gray_o !== 4'b0001) begin
      n_mis++;
      $display("FAIL after_reset_step: got bin=%0d gray=%b want 1/0001", bin_o, gray_o);
    end
  endtask

  task automatic test_load_step();
    cycle(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    n_cmp++;
    if (bin_o !== 4'd7 || gray_o !== 4'b0100 || wrap_o !== 1'b0) begin
      n_mis++;
      $display("FAIL load7: got bin=%0d gray=%b wrap=%b want 7/0100/0", bin_o, gray_o, wrap_o);
    end
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    n_cmp++;
    if (bin_o !== 4'd8 || gray_o !== 4'b1100 || chg_o !== 4'b1000) begin
      n_mis++;
      $display("FAIL step_to_8: got bin=%0d gray=%b chg=%b want 8/1100/1000", bin_o, gray_o, chg_o);
    end
  endtask

  task automatic test_up_wrap();
    cycle(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    n_cmp++;
    if (gray_o !== 4'b1000 || wrap_o !== 1'b0) begin
      n_mis++;
      $display("FAIL load15: got gray=%b wrap=%b want 1000/0", gray_o, wrap_o);
    end
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    n_cmp++;
`ifdef GRAY_CNT_SAT_EN
    if ({bin_o, gray_o, chg_o, wrap_o} !== {4'd15, 4'b1000, 4'b0000, 1'b1}) begin
      n_mis++;
      $display("FAIL up_sat: got %b want %b", {bin_o, gray_o, chg_o, wrap_o},
               {4'd15, 4'b1000, 4'b0000, 1'b1});
    end
`else
    if ({bin_o, gray_o, chg_o, wrap_o} !== {4'd0, 4'b0000, 4'b1000, 1'b1}) begin
      n_mis++;
      $display("FAIL up_wrap: got %b want %b", {bin_o, gray_o, chg_o, wrap_o},
               {4'd0, 4'b0000, 4'b1000, 1'b1});
    end
`endif
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (wrap_o !== 1'b0 || chg_o !== 4'b0000) begin
      n_mis++;
      $display("FAIL wrap_one_cycle: got wrap=%b chg=%b want 0/0000", wrap_o, chg_o);
    end
  endtask

  task automatic test_down_wrap();
    int guard;
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    n_cmp++;
    if ({bin_o, gray_o, chg_o, wrap_o} !== {e_bin, e_gray, e_chg, e_wrap} || wrap_o !== 1'b1) begin
      n_mis++;
      $display("FAIL down_wrap: got %b want %b", {bin_o, gray_o, chg_o, wrap_o},
               {e_bin, e_gray, e_chg, 1'b1});
    end
`ifdef GRAY_CNT_SAT_EN
    cycle(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
`else
    n_cmp++;
    if (bin_o !== 4'd15 || gray_o !== 4'b1000) begin
      n_mis++;
      $display("FAIL down_wrap_val: got bin=%0d gray=%b want 15/1000", bin_o, gray_o);
    end
`endif
    guard = 0;
    while (m_cnt != 4 && guard < 20) begin
      cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      guard++;
    end
    n_cmp++;
    if (bin_o !== 4'd4 || gray_o !== 4'b0110 || wrap_o !== 1'b0) begin
      n_mis++;
      $display("FAIL down_to_4: got bin=%0d gray=%b wrap=%b want 4/0110/0", bin_o, gray_o, wrap_o);
    end
  endtask

  task automatic test_priority();
    cycle(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    n_cmp++;
    if (bin_o !== 4'd0 || gray_o !== 4'd0 || wrap_o !== 1'b0) begin
      n_mis++;
      $display("FAIL prio_clr: got bin=%0d gray=%b wrap=%b want 0/0000/0", bin_o, gray_o, wrap_o);
    end
    cycle(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    n_cmp++;
    if (bin_o !== 4'd5 || gray_o !== 4'b0111 || wrap_o !== 1'b0) begin
      n_mis++;
      $display("FAIL prio_load: got bin=%0d gray=%b wrap=%b want 5/0111/0", bin_o, gray_o, wrap_o);
    end
    cycle(1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
    n_cmp++;
    if (bin_o !== 4'd5 || chg_o !== 4'b0000 || wrap_o !== 1'b0) begin
      n_mis++;
      $display("FAIL load_same: got bin=%0d chg=%b wrap=%b want 5/0000/0", bin_o, chg_o, wrap_o);
    end
    cycle(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    n_cmp++;
    if (bin_o !== 4'd0 || wrap_o !== 1'b0) begin
      n_mis++;
      $display("FAIL load_limit_nowrap: got bin=%0d wrap=%b want 0/0", bin_o, wrap_o);
    end
  endtask

  task automatic test_walk(input logic up, input string name);
    int wraps;
    int exp_wraps;
    wraps = 0;
    exp_wraps = 0;
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b0, 4'd0, 1'b1, up);
      if (wrap_o === 1'b1) wraps++;
      if (e_wrap) exp_wraps++;
      n_cmp++;
      if ({bin_o, gray_o, chg_o, wrap_o} !== {e_bin, e_gray, e_chg, e_wrap} ||
          (e_chg != 4'd0 && !$onehot(chg_o))) begin
        n_mis++;
        $display("FAIL walk_%s[%0d]: got %b want %b", name, i,
                 {bin_o, gray_o, chg_o, wrap_o}, {e_bin, e_gray, e_chg, e_wrap});
      end
    end
    n_cmp++;
`ifdef GRAY_CNT_SAT_EN
    if (wraps != exp_wraps) begin
`else
    if (wraps != 2) begin
`endif
      n_mis++;
      $display("FAIL walk_%s_wraps: got %0d want %0d", name, wraps, exp_wraps);
    end
  endtask

  task automatic test_random();
    logic c, l, e, u;
    logic [3:0] v;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) == 1;
      v = 4'($urandom_range(0, 15));
      cycle(c, l, v, e, u);
      n_cmp++;
      if ({bin_o, gray_o, chg_o, wrap_o} !== {e_bin, e_gray, e_chg, e_wrap}) begin
        n_mis++;
        $display("FAIL random[%0d]: got %b want %b", i,
                 {bin_o, gray_o, chg_o, wrap_o}, {e_bin, e_gray, e_chg, e_wrap});
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_step();
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_walk(1'b1, "up");
    test_walk(1'b0, "down");
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
